// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the digit-serial BCD adder.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD add stage: digit = ad + bd + cin with decimal correction.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] ad,
  input  logic [DIGIT_W-1:0] bd,
  input  logic               cin,
  output logic [DIGIT_W-1:0] digit,
  output logic               cy
);

  logic [DIGIT_W:0] s;

  // Invalid digits go through the same rule; the wrap of s[3:0]+6 is intended.
  always_comb begin
    s = {1'b0, ad} + {1'b0, bd} + {{DIGIT_W{1'b0}}, cin};
    if (s > {1'b0, BCD_MAX}) begin
      digit = s[DIGIT_W-1:0] + BCD_CORR;
      cy    = 1'b1;
    end else begin
      digit = s[DIGIT_W-1:0];
      cy    = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial NDIGITS-digit BCD adder controller, LSD first, one digit per clock.
// Optional macro BCD_SUB_EN adds a `sub` input for ten's-complement subtraction.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
`ifdef BCD_SUB_EN
  input  logic                       sub,
`endif
  input  logic [DIGIT_W*NDIGITS-1:0] a,
  input  logic [DIGIT_W*NDIGITS-1:0] b,
  output logic                       busy,
  output logic                       done,
  output logic [DIGIT_W*NDIGITS-1:0] sum,
  output logic                       cout,
  output logic                       err
);

  localparam int W     = DIGIT_W * NDIGITS;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_t             state, state_next;
  logic [W-1:0]       a_sh, b_sh, b_load;
  logic               carry, carry_init;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic [DIGIT_W-1:0] digit;
  logic               cy;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    has_bad_digit = 1'b0;
    for (int i = 0; i < NDIGITS; i++)
      if (v[i*DIGIT_W +: DIGIT_W] > BCD_MAX) has_bad_digit = 1'b1;
  endfunction

  // Subtraction feeds the nine's complement of B with an initial carry of one.
  always_comb begin
    b_load     = b;
    carry_init = 1'b0;
`ifdef BCD_SUB_EN
    if (sub) begin
      for (int i = 0; i < NDIGITS; i++)
        b_load[i*DIGIT_W +: DIGIT_W] = BCD_MAX - b[i*DIGIT_W +: DIGIT_W];
      carry_init = 1'b1;
    end
`endif
  end

  bcd_digit_add u_digit (
    .ad    (a_sh[DIGIT_W-1:0]),
    .bd    (b_sh[DIGIT_W-1:0]),
    .cin   (carry),
    .digit (digit),
    .cy    (cy)
  );

  assign last = (cnt == CNT_W'(NDIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cout is captured on the last digit so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b_load;
          carry <= carry_init;
          cnt   <= '0;
          sum   <= '0;
          err   <= has_bad_digit(a) | has_bad_digit(b);
        end
        RUN: begin
          sum   <= (sum >> DIGIT_W) | (W'(digit) << (W - DIGIT_W));
          a_sh  <= a_sh >> DIGIT_W;
          b_sh  <= b_sh >> DIGIT_W;
          carry <= cy;
          cnt   <= cnt + CNT_W'(1);
          if (last) cout <= cy;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl (NDIGITS=4); honours BCD_SUB_EN when defined.
module tb_bcd_serial_add_ctrl;

  localparam int ND = 4;
  localparam int W  = 4 * ND;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;
`ifdef BCD_SUB_EN
  logic         sub = 1'b0;
`endif

  bcd_serial_add_ctrl #(.NDIGITS(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef BCD_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   done_seen = 0;
  int   busy_cnt = 0;
  int   ops_expected = 0;
  logic [W-1:0] last_sum;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum", 64'(sum), 64'(e.sum));
          check("cout", 64'(cout), 64'(e.cout));
          check("err", 64'(err), 64'(e.err));
          check("latency", 64'(cyc - e.cyc), 64'(ND));
          check("busy_cycles", 64'(busy_cnt), 64'(ND + 1));
        end
        busy_cnt = 0;
        done_seen++;
      end
    end
  end

  // Presents one start pulse; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                       input logic [W-1:0] es, input logic ec, input logic ee, input bit push);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; a = va; b = vb;
`ifdef BCD_SUB_EN
    sub = vs;
`endif
    if (push) begin
      e.sum = es; e.cout = ec; e.err = ee; e.cyc = cyc + 1;
      sb.push_back(e);
      ops_expected++;
      last_sum = es;
    end
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
`ifdef BCD_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  task automatic wait_done();
    int target = done_seen + 1;
    int n = 0;
    while (done_seen < target && n < 30) begin
      @(posedge clk);
      n++;
    end
    if (done_seen < target) check("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1); wait_done();
    issue(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1); wait_done();
    issue(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1); wait_done();
    issue(16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b1, 1); wait_done();
    issue(16'hF000, 16'h0000, 1'b0, 16'h5000, 1'b1, 1'b1, 1); wait_done();
    issue(16'h0909, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1); wait_done();
    // Back-to-back: next start on the first IDLE cycle after DONE.
    issue(16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
    @(negedge clk);
    while (!done) @(negedge clk);
    issue(16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 1); wait_done();

    // Start while busy must be ignored.
    issue(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1);
    @(posedge clk); #1;
    start = 1'b1; a = 16'h9999; b = 16'h9999;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (8) @(posedge clk);
    check("single_done", 64'(done_seen), 64'(ops_expected));

    // Asynchronous reset mid-RUN abandons the operation.
    issue(16'h2222, 16'h3333, 1'b0, '0, 1'b0, 1'b0, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    check("no_done_after_rst", 64'(done_seen), 64'(ops_expected));
    issue(16'h0045, 16'h0055, 1'b0, 16'h0100, 1'b0, 1'b0, 1); wait_done();

`ifdef BCD_SUB_EN
    issue(16'h0100, 16'h0001, 1'b1, 16'h0099, 1'b1, 1'b0, 1); wait_done();
    issue(16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0, 1); wait_done();
`endif

    // Result must hold after done while inputs wander.
    repeat (4) @(posedge clk);
    #1 check("sum_hold", 64'(sum), 64'(last_sum));
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
